// File: rtl/cp0_intc.sv
// Coprocessor-0 register file and interrupt entry/return control.
// Holds SR/Cause/EPC/PRId and raises IntReq from the live device IRQ lines.
module cp0_intc #(
    parameter logic [31:0] PRID_VAL = 32'h4C59_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  A1,
    input  logic [31:0] DIn,
    input  logic        we,
    input  logic [29:0] PC,
    input  logic        EXLSet,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // EXL is the state bit itself: HANDLER means an exception is being serviced.
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  im, im_nxt;
    logic        ie, ie_nxt;
    logic [29:0] epc_q, epc_nxt;
    logic [5:0]  ip_q;
    logic        exl;
    logic        sr_we;
    logic        epc_we;

    assign exl    = (state == HANDLER);
    assign sr_we  = we && (A1 == REG_SR);
    assign epc_we = we && (A1 == REG_EPC);

    // Level-sensitive on the live lines: no pending latch, zero latency.
    assign IntReq = (|(HWInt & im)) & ie & ~exl;
    assign EPC    = epc_q;

    always_comb begin
        state_nxt = state;
        im_nxt    = im;
        ie_nxt    = ie;
        epc_nxt   = epc_q;
        if (IntReq) begin
            // The interrupted instruction is flushed, so its mtc0 must not land.
            state_nxt = HANDLER;
            epc_nxt   = PC;
        end else begin
            if (sr_we) begin
                im_nxt = DIn[15:10];
                ie_nxt = DIn[0];
            end
            if (epc_we)
                epc_nxt = DIn[31:2];
            if (EXLSet)
                state_nxt = HANDLER;
            else if (EXLClr)
                state_nxt = NORMAL;
            else if (sr_we)
                state_nxt = DIn[1] ? HANDLER : NORMAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NORMAL;
            im    <= '0;
            ie    <= 1'b0;
            epc_q <= '0;
        end else begin
            state <= state_nxt;
            im    <= im_nxt;
            ie    <= ie_nxt;
            epc_q <= epc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ip_q <= '0;
        else
            ip_q <= HWInt;
    end

    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = {16'b0, im, 8'b0, exl, ie};
            REG_CAUSE: DOut = {16'b0, ip_q, 10'b0};
            REG_EPC:   DOut = {epc_q, 2'b00};
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Table-driven check of cp0_intc with a queue of expected outputs, plus
// hand-written sequences for mid-cycle IRQ glitches and async reset.
module tb_cp0_intc;

    localparam logic [31:0] PRID = 32'h4C59_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1;
    logic [31:0] DIn;
    logic        we;
    logic [29:0] PC;
    logic        EXLSet;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    cp0_intc #(.PRID_VAL(PRID)) dut (
        .clk(clk), .rst(rst), .A1(A1), .DIn(DIn), .we(we), .PC(PC),
        .EXLSet(EXLSet), .EXLClr(EXLClr), .HWInt(HWInt),
        .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  a1;
        logic [31:0] din;
        logic [29:0] pc;
        logic        set;
        logic        clr;
        logic [5:0]  hw;
        logic        exp_int;
        logic [31:0] exp_dout;
        logic [29:0] exp_epc;
    } vec_t;

    typedef struct {
        logic        irq;
        logic [31:0] dout;
        logic [29:0] epc;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic r, logic w, logic [4:0] a, logic [31:0] d,
                                logic [29:0] p, logic s, logic c, logic [5:0] h,
                                logic ei, logic [31:0] ed, logic [29:0] ee);
        vec_t v;
        v.rst = r; v.we = w; v.a1 = a; v.din = d; v.pc = p; v.set = s; v.clr = c;
        v.hw = h; v.exp_int = ei; v.exp_dout = ed; v.exp_epc = ee;
        return v;
    endfunction

    task automatic push_exp(logic ei, logic [31:0] ed, logic [29:0] ee);
        exp_t e;
        e.irq = ei; e.dout = ed; e.epc = ee;
        sb.push_back(e);
    endtask

    task automatic check_out(string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (IntReq !== e.irq) begin
            n_bad++;
            $display("FAIL %s IntReq: got %b want %b", nm, IntReq, e.irq);
        end
        n_cmp++;
        if (DOut !== e.dout) begin
            n_bad++;
            $display("FAIL %s DOut(A1=%0d): got %h want %h", nm, A1, DOut, e.dout);
        end
        n_cmp++;
        if (EPC !== e.epc) begin
            n_bad++;
            $display("FAIL %s EPC: got %h want %h", nm, EPC, e.epc);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; A1 = 5'd12; DIn = '0; PC = '0; EXLSet = 1'b0; EXLClr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        HWInt = '0;

        //                rst we a1  din           pc      set clr hw  int dout          epc
        vt.push_back(mk(1, 0, 12, 32'h0,         30'h0,   0, 0, 6'd0, 0, 32'h0,         30'h0));
        vt.push_back(mk(1, 0, 14, 32'h0,         30'h0,   0, 0, 6'd0, 0, 32'h0,         30'h0));
        vt.push_back(mk(1, 0, 15, 32'h0,         30'h0,   0, 0, 6'd0, 0, PRID,          30'h0));
        vt.push_back(mk(0, 1, 12, 32'h0000_0401, 30'hC00, 0, 0, 6'd1, 0, 32'h0,         30'h0));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'hC00, 0, 0, 6'd1, 1, 32'h0000_0401, 30'h0));
        vt.push_back(mk(0, 0, 14, 32'h0,         30'h0,   0, 0, 6'd1, 0, 32'h0000_3000, 30'hC00));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 0, 6'd1, 0, 32'h0000_0403, 30'hC00));
        vt.push_back(mk(0, 0, 13, 32'h0,         30'h0,   0, 0, 6'd1, 0, 32'h0000_0400, 30'hC00));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 1, 6'd1, 0, 32'h0000_0403, 30'hC00));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h100, 0, 0, 6'd1, 1, 32'h0000_0401, 30'hC00));
        vt.push_back(mk(0, 0, 14, 32'h0,         30'h0,   0, 0, 6'd1, 0, 32'h0000_0400, 30'h100));
        vt.push_back(mk(0, 1, 12, 32'h0000_0801, 30'h0,   0, 1, 6'd1, 0, 32'h0000_0403, 30'h100));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 0, 6'd1, 0, 32'h0000_0801, 30'h100));
        vt.push_back(mk(0, 0, 13, 32'h0,         30'h0,   0, 0, 6'd0, 0, 32'h0000_0400, 30'h100));
        vt.push_back(mk(0, 0, 13, 32'h0,         30'h0,   0, 0, 6'd0, 0, 32'h0,         30'h100));
        vt.push_back(mk(0, 1, 12, 32'h0000_0403, 30'h0,   0, 0, 6'd0, 0, 32'h0000_0801, 30'h100));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 0, 6'd1, 0, 32'h0000_0403, 30'h100));
        vt.push_back(mk(0, 1, 12, 32'h0000_0401, 30'h0,   0, 0, 6'd1, 0, 32'h0000_0403, 30'h100));
        vt.push_back(mk(0, 1, 14, 32'hDEAD_BEEF, 30'h2AB, 0, 0, 6'd1, 1, 32'h0000_0400, 30'h100));
        vt.push_back(mk(0, 0, 14, 32'h0,         30'h0,   0, 0, 6'd1, 0, 32'h0000_0AAC, 30'h2AB));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 0, 6'd0, 0, 32'h0000_0403, 30'h2AB));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   1, 1, 6'd0, 0, 32'h0000_0403, 30'h2AB));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 0, 6'd1, 0, 32'h0000_0403, 30'h2AB));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 1, 6'd0, 0, 32'h0000_0403, 30'h2AB));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h3FF, 1, 0, 6'd0, 0, 32'h0000_0401, 30'h2AB));
        vt.push_back(mk(0, 0, 14, 32'h0,         30'h0,   0, 0, 6'd0, 0, 32'h0000_0AAC, 30'h2AB));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 1, 6'd0, 0, 32'h0000_0403, 30'h2AB));
        vt.push_back(mk(0, 0, 12, 32'h0,         30'h0,   0, 0, 6'd0, 0, 32'h0000_0401, 30'h2AB));

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            rst = vt[i].rst; we = vt[i].we; A1 = vt[i].a1; DIn = vt[i].din;
            PC = vt[i].pc; EXLSet = vt[i].set; EXLClr = vt[i].clr; HWInt = vt[i].hw;
            push_exp(vt[i].exp_int, vt[i].exp_dout, vt[i].exp_epc);
            @(negedge clk);
            check_out($sformatf("vec%0d", i));
        end

        // IRQ pulses high and drops before the edge: nothing is captured.
        @(posedge clk); #1;
        idle_inputs(); A1 = 5'd12; HWInt = 6'd1; PC = 30'h77;
        #2;
        push_exp(1'b1, 32'h0000_0401, 30'h2AB);
        check_out("glitch_hi");
        HWInt = 6'd0;
        @(negedge clk);
        push_exp(1'b0, 32'h0000_0401, 30'h2AB);
        check_out("glitch_lo");
        @(posedge clk); #1;
        A1 = 5'd14;
        @(negedge clk);
        push_exp(1'b0, 32'h0000_0AAC, 30'h2AB);
        check_out("no_pending");

        // Enter the handler, then assert reset mid-cycle with the IRQ still high.
        @(posedge clk); #1;
        A1 = 5'd12; HWInt = 6'd1; PC = 30'h55;
        @(negedge clk);
        push_exp(1'b1, 32'h0000_0401, 30'h2AB);
        check_out("entry2");
        @(posedge clk); #1;
        @(negedge clk);
        push_exp(1'b0, 32'h0000_0403, 30'h55);
        check_out("in_handler");
        #1 rst = 1'b1;
        #1;
        push_exp(1'b0, 32'h0, 30'h0);
        check_out("rst_sr");
        A1 = 5'd13; #1;
        push_exp(1'b0, 32'h0, 30'h0);
        check_out("rst_cause");
        A1 = 5'd14; #1;
        push_exp(1'b0, 32'h0, 30'h0);
        check_out("rst_epc");

        @(posedge clk); #1;
        rst = 1'b0; HWInt = 6'd0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
